// File: rtl/morse_seq_queue_if.sv
// morse_seq_queue_if: symbol input, abort and sequence FIFO handshake bundle for morse_seq_queue
interface morse_seq_queue_if #(
  parameter int MAX_SYMBOLS = 5,
  parameter int DEPTH = 4
);
  logic [2:0] signals_i;
  logic clear_i;
  logic seq_ready_i;
  logic seq_valid_o;
  logic [2*MAX_SYMBOLS-1:0] seq_out_o;
  logic [$clog2(MAX_SYMBOLS+1)-1:0] seq_len_o;
  logic seq_kind_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic error_o;
  modport master (
    input signals_i, clear_i, seq_ready_i,
    output seq_valid_o, seq_out_o, seq_len_o, seq_kind_o, count_o, error_o
  );
  modport slave (
    output signals_i, clear_i, seq_ready_i,
    input seq_valid_o, seq_out_o, seq_len_o, seq_kind_o, count_o, error_o
  );
endinterface

// File: rtl/morse_seq_queue.sv
// morse_seq_queue: edge-detected Morse symbol assembler feeding a DEPTH-entry sequence FIFO
// MORSE_SEQ_ERR_EN enables the sticky error flag and invalid-code aborts.
module morse_seq_queue #(
  parameter int MAX_SYMBOLS = 5,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  morse_seq_queue_if.master bus
);
  localparam int SW = 2 * MAX_SYMBOLS;
  localparam int LW = $clog2(MAX_SYMBOLS + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [2:0] sig_prev_q;
  logic [SW-1:0] slots_q, slots_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] mem_seq_q [DEPTH];
  logic [LW-1:0] mem_len_q [DEPTH];
  logic mem_kind_q [DEPTH];
  logic evt, is_sym, is_term, pop, push, abort, valid;
  assign evt = sig_prev_q == 3'b000 && bus.signals_i != 3'b000 && !bus.clear_i;
  assign is_sym = evt && (bus.signals_i == 3'b001 || bus.signals_i == 3'b010);
  assign is_term = evt && (bus.signals_i == 3'b011 || bus.signals_i == 3'b100);
  assign valid = count_q != '0;
  assign pop = valid && bus.seq_ready_i;
  // a same-cycle pop frees the slot, so a push into a full FIFO still lands
  assign push = is_term && (count_q != CW'(DEPTH) || pop);
`ifdef MORSE_SEQ_ERR_EN
  logic err_q, err_d, is_inv;
  assign is_inv = evt && bus.signals_i[2] && bus.signals_i[1:0] != 2'b00;
  assign abort = bus.clear_i || is_term || is_inv;
  assign err_d = !bus.clear_i && (err_q || (is_sym && len_q == LW'(MAX_SYMBOLS))
                                  || (is_term && !push) || is_inv);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign bus.error_o = err_q;
`else
  assign abort = bus.clear_i || is_term;
  assign bus.error_o = 1'b0;
`endif
  always_comb begin
    slots_d = slots_q;
    len_d = len_q;
    if (abort) begin
      slots_d = '1;
      len_d = '0;
    end else if (is_sym && len_q != LW'(MAX_SYMBOLS)) begin
      // slot 0 occupies the MSBs; Dot 001 -> 00, Dash 010 -> 01
      for (int i = 0; i < MAX_SYMBOLS; i++)
        if (LW'(i) == len_q) slots_d[SW-1-2*i -: 2] = {1'b0, bus.signals_i[1]};
      len_d = len_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_prev_q <= 3'b000;
      slots_q <= '1;
      len_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      sig_prev_q <= bus.signals_i;
      slots_q <= slots_d;
      len_q <= len_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_seq_q[wr_q] <= slots_q;
      mem_len_q[wr_q] <= len_q;
      mem_kind_q[wr_q] <= bus.signals_i == 3'b011;
    end
  end
  assign bus.seq_valid_o = valid;
  assign bus.seq_out_o = valid ? mem_seq_q[rd_q] : '1;
  assign bus.seq_len_o = valid ? mem_len_q[rd_q] : '0;
  assign bus.seq_kind_o = valid ? mem_kind_q[rd_q] : 1'b0;
  assign bus.count_o = count_q;
endmodule

// File: doc/morse_seq_queue.md
# morse_seq_queue

Clocked, parametrised successor to the combinational sequence producer/separator pair. It takes the 3-bit symbol code from the morse code encoder and detects symbol events on edges, so a held button counts once. It assembles Dot/Dash symbols into sequences of up to MAX_SYMBOLS, closes a sequence on Space or EndSeq, and queues completed sequences in a DEPTH-entry FIFO. The FIFO drains through a valid/ready handshake to the translator stage.

## Interface
- MAX_SYMBOLS, 5: symbol slots per sequence, at least 1.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- Clk  in  1  system clock, rising edge.
- Resetbar  in  1  asynchronous, active-low reset.
- Signals  in  3  symbol code.
  - 000 idle, 001 Dot, 010 Dash, 011 Space, 100 EndSeq.
  - 101–111 invalid.
- Clear  in  1  synchronous abort of the sequence in progress.
- SeqReady  in  1  consumer accepts the head entry.
- SeqValid  out  1  FIFO non-empty.
- SeqOut  out  2*MAX_SYMBOLS  head sequence.
  - Slot 0 sits in the MSBs.
  - Slot codes: 00 Dot, 01 Dash, 11 empty.
- SeqLen  out  $clog2(MAX_SYMBOLS+1)  number of symbols in the head entry.
- SeqKind  out  1  head terminator: 1 Space, 0 EndSeq.
- Count  out  $clog2(DEPTH+1)  FIFO occupancy.
- Error  out  1  sticky error flag.

## Operation
- Reset values: SigPrev=000, assembly slots all 11, assembly length 0, FIFO empty.
  - Outputs: SeqValid=0, SeqOut all ones, SeqLen=0, SeqKind=0, Count=0, Error=0.
- Event detection: event = (SigPrev==000) && (Signals!=000). SigPrev <= Signals every cycle.
  - A code held N cycles yields one event.
  - A direct change from one nonzero code to another yields no event.
- Dot/Dash event:
  - Length < MAX_SYMBOLS: write 00/01 into slot[length], length+1.
  - Length = MAX_SYMBOLS: symbol dropped, Error set.
- Space/EndSeq event: push {slots, length, kind} into the FIFO, then reset the assembly to all-11 / length 0.
  - Zero-length sequences are pushed; a bare Space yields an empty Space entry.
- Push when full: the entry is dropped, Error is set, and the assembly is still reset.
  - Exception: a pop in the same cycle frees the slot, so the push succeeds.
- Pop: on SeqValid && SeqReady at a rising edge; the head advances.
- Outputs: SeqOut/SeqLen/SeqKind show the head combinationally from FIFO storage.
  - Values are undefined-free: all-ones/0/0 when empty.
- Clear: discards the assembly only; FIFO contents and Count are retained. Clear also clears Error.
  - Clear together with any event: Clear wins, the event is ignored, no push.
- Invalid code event: see Configuration.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; Count tracks occupancy 0..DEPTH.

## Timing
- Event at edge k (Signals nonzero before edge k, SigPrev==000): assembly or FIFO updated at edge k.
- Terminator into an empty FIFO: SeqValid=1 immediately after edge k. Latency is 1 edge.
- Pop at edge k: the next entry is visible after edge k.
- Simultaneous push and pop: Count unchanged.
- Resetbar low at any time, mid-sequence included: all state clears immediately, with no clock needed.
  - Release is synchronised externally.
- Minimum symbol spacing: 1 cycle of 000 between codes.

## Configuration
- Macro: MORSE_SEQ_ERR_EN.
- Defined:
  - Error is set by an over-length symbol, a FIFO overflow, or an invalid-code event.
  - An invalid-code event also aborts the current assembly, with no push.
- Undefined:
  - Error is tied 0.
  - Invalid-code events are ignored.
  - Over-length symbols and overflow pushes are dropped silently.

## Test plan
- Sequence entry, MAX_SYMBOLS=5, SeqReady=0:
  - Stimulus: Dot, Dash, Dot, Dot, Dash, then EndSeq, each held 2 cycles with idle gaps.
  - Response: SeqValid=1, SeqOut=10'b00_01_00_00_01, SeqLen=5, SeqKind=0, Count=1.
- Bare Space after the previous test, no pop:
  - Count=2.
  - After one pop: SeqOut=10'b11_11_11_11_11, SeqLen=0, SeqKind=1.
- Held symbol:
  - Stimulus: Dot held 6 cycles, then Space.
  - Response: single-symbol entry SeqOut=10'b00_11_11_11_11, SeqLen=1.
- Over-length, macro defined:
  - Stimulus: 6 Dashes, then EndSeq.
  - Response: SeqOut=10'b01_01_01_01_01, SeqLen=5, Error=1. A following Clear gives Error=0.
- FIFO full, DEPTH=4, SeqReady=0:
  - Stimulus: 5 EndSeq events.
  - Response: Count=4, Error=1.
  - Then SeqReady=1 plus an EndSeq in the same cycle: Count stays 4.
- Clear and reset mid-operation:
  - Dot, then Clear, then EndSeq: an entry with SeqLen=0.
  - Dot, Resetbar pulse low, then EndSeq:
    - During the pulse, asynchronously: Count=0, SeqValid=0.
    - After EndSeq: a single entry with SeqLen=0.
